// File: rtl/hxd_ram.sv
// hxd32 unified memory: word-organised IRAM and DRAM shared between the UART loader
// (byte port, registered read) and the core (combinational fetch/load, byte-enabled store).
module hxd_ram #(
    parameter int XLEN       = 32,
    parameter int IRAM_DEPTH = 2048,
    parameter int DRAM_DEPTH = 2048
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            ram_rw_sel_i,
    input  logic [XLEN-1:0] ram_rw_addr_i,
    input  logic [7:0]      ram_wr_data_i,
    input  logic [3:0]      ram_wr_byte_en_i,
    input  logic [XLEN-1:0] iram_rd_addr_i,
    input  logic [XLEN-1:0] dram_rd_addr_i,
    input  logic [XLEN-1:0] dram_wr_addr_i,
    input  logic [XLEN-1:0] dram_wr_data_i,
    input  logic [3:0]      dram_wr_byte_en_i,
    output logic [XLEN-1:0] iram_rd_data_o,
    output logic [XLEN-1:0] dram_rd_data_o,
    output logic [7:0]      ram_rd_data_o
);

    localparam int IW = $clog2(IRAM_DEPTH);
    localparam int DW = $clog2(DRAM_DEPTH);

    logic [XLEN-1:0] iram [IRAM_DEPTH];
    logic [XLEN-1:0] dram [DRAM_DEPTH];

    logic [IW-1:0]   ld_iidx;
    logic [DW-1:0]   ld_didx;
    logic [1:0]      ld_lane;
    logic            ld_dram;
    logic [IW-1:0]   fetch_idx;
    logic [DW-1:0]   load_idx;
    logic [DW-1:0]   store_idx;
    logic [XLEN-1:0] ld_word;
    logic [7:0]      ld_byte;

    // Address bits above the region index are don't-care; addresses alias modulo region size.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{ram_rw_addr_i, iram_rd_addr_i, dram_rd_addr_i, dram_wr_addr_i};

    assign ld_iidx   = ram_rw_addr_i[IW+1:2];
    assign ld_didx   = ram_rw_addr_i[DW+1:2];
    assign ld_lane   = ram_rw_addr_i[1:0];
    assign ld_dram   = ram_rw_addr_i[28];
    assign fetch_idx = iram_rd_addr_i[IW+1:2];
    assign load_idx  = dram_rd_addr_i[DW+1:2];
    assign store_idx = dram_wr_addr_i[DW+1:2];

    assign iram_rd_data_o = iram[fetch_idx];
    assign dram_rd_data_o = dram[load_idx];

    always_ff @(posedge clk_i) begin
        if (ram_rw_sel_i && !ld_dram) begin
            for (int n = 0; n < 4; n++) begin
                if (ram_wr_byte_en_i[n]) iram[ld_iidx][8*n +: 8] <= ram_wr_data_i;
            end
        end
    end

    // The single DRAM writer is chosen by ownership, so loader and core never collide.
    always_ff @(posedge clk_i) begin
        if (ram_rw_sel_i) begin
            if (ld_dram) begin
                for (int n = 0; n < 4; n++) begin
                    if (ram_wr_byte_en_i[n]) dram[ld_didx][8*n +: 8] <= ram_wr_data_i;
                end
            end
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (dram_wr_byte_en_i[n]) dram[store_idx][8*n +: 8] <= dram_wr_data_i[8*n +: 8];
            end
        end
    end

    always_comb begin
        ld_word = ld_dram ? dram[ld_didx] : iram[ld_iidx];
        ld_byte = ld_word[7:0];
        case (ld_lane)
            2'd0:    ld_byte = ld_word[7:0];
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) ram_rd_data_o <= 8'h00;
        else          ram_rd_data_o <= ld_byte;
    end

endmodule

// File: tb/tb_hxd_ram.sv
// Scoreboard bench for hxd_ram: byte-level memory model, directed scenarios, then random traffic.
module tb_hxd_ram;
    localparam int IRAM_DEPTH = 2048;
    localparam int DRAM_DEPTH = 2048;
    localparam int IB = IRAM_DEPTH * 4;
    localparam int DB = DRAM_DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b1;
    logic [31:0] rw_addr = '0;
    logic [7:0]  wr_data = '0;
    logic [3:0]  wr_en = '0;
    logic [31:0] ia = '0, dra = '0, dwa = '0, dwd = '0;
    logic [3:0]  den = '0;
    logic [31:0] iram_q, dram_q;
    logic [7:0]  rd_q;

    hxd_ram #(.XLEN(32), .IRAM_DEPTH(IRAM_DEPTH), .DRAM_DEPTH(DRAM_DEPTH)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .ram_rw_sel_i(sel), .ram_rw_addr_i(rw_addr),
        .ram_wr_data_i(wr_data), .ram_wr_byte_en_i(wr_en), .iram_rd_addr_i(ia),
        .dram_rd_addr_i(dra), .dram_wr_addr_i(dwa), .dram_wr_data_i(dwd),
        .dram_wr_byte_en_i(den), .iram_rd_data_o(iram_q), .dram_rd_data_o(dram_q),
        .ram_rd_data_o(rd_q)
    );

    always #5 clk = ~clk;

    // Byte-addressed reference model with a "known" flag per byte (arrays power up undefined).
    logic [7:0] imem [IB];
    logic [7:0] dmem [DB];
    bit         ik [IB];
    bit         dk [DB];

    typedef struct { bit iv; logic [31:0] ie; bit dv; logic [31:0] de; } comb_t;
    typedef struct { bit v; logic [7:0] b; } byte_t;
    comb_t cq[$];
    byte_t pend[$];
    byte_t ready[$];

    int errors = 0;
    int checks = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int ibase(logic [31:0] a); return (a % IB) & ~3; endfunction
    function automatic int dbase(logic [31:0] a); return (a % DB) & ~3; endfunction

    task automatic step(input logic s, input logic [31:0] la, input logic [7:0] lwd,
                        input logic [3:0] len, input logic [31:0] fa, input logic [31:0] lda,
                        input logic [31:0] swa, input logic [31:0] swd, input logic [3:0] sen);
        comb_t c;
        byte_t r;
        int bi, bd, bl;
        @(posedge clk); #2;
        sel = s; rw_addr = la; wr_data = lwd; wr_en = len;
        ia = fa; dra = lda; dwa = swa; dwd = swd; den = sen;
        bi = ibase(fa);
        bd = dbase(lda);
        c.iv = ik[bi] && ik[bi+1] && ik[bi+2] && ik[bi+3];
        c.ie = {imem[bi+3], imem[bi+2], imem[bi+1], imem[bi]};
        c.dv = dk[bd] && dk[bd+1] && dk[bd+2] && dk[bd+3];
        c.de = {dmem[bd+3], dmem[bd+2], dmem[bd+1], dmem[bd]};
        cq.push_back(c);
        if (la[28]) begin
            bl = (la % DB); r.v = dk[bl]; r.b = dmem[bl];
        end else begin
            bl = (la % IB); r.v = ik[bl]; r.b = imem[bl];
        end
        pend.push_back(r);
        if (s) begin
            for (int n = 0; n < 4; n++) begin
                if (len[n]) begin
                    if (la[28]) begin dmem[dbase(la)+n] = lwd; dk[dbase(la)+n] = 1'b1; end
                    else        begin imem[ibase(la)+n] = lwd; ik[ibase(la)+n] = 1'b1; end
                end
            end
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (sen[n]) begin dmem[dbase(swa)+n] = swd[8*n +: 8]; dk[dbase(swa)+n] = 1'b1; end
            end
        end
    endtask

    task automatic idle(input logic [31:0] la, input logic [31:0] fa, input logic [31:0] lda);
        step(1'b1, la, 8'h00, 4'b0000, fa, lda, 32'h0, 32'h0, 4'b0000);
    endtask

    task automatic sample;
        @(negedge clk); #1;
    endtask

    // Loader read results appear on the edge after issue; comb results within the same cycle.
    always @(posedge clk) begin
        if (pend.size() > 0) ready.push_back(pend.pop_front());
    end

    always @(negedge clk) begin
        byte_t r;
        comb_t c;
        while (ready.size() > 0) begin
            r = ready.pop_front();
            if (r.v) chk("loader_rd", {24'h0, rd_q}, {24'h0, r.b});
        end
        if (cq.size() > 0) begin
            c = cq.pop_front();
            if (c.iv) chk("iram_fetch", iram_q, c.ie);
            if (c.dv) chk("dram_load", dram_q, c.de);
        end
    end

    function automatic logic [31:0] mk_addr(int idx, int lane, bit region);
        logic [31:0] a;
        a = $urandom;
        a[12:2] = 11'(idx);
        a[1:0] = 2'(lane);
        a[28] = region;
        return a;
    endfunction

    task automatic do_reset;
        sample();
        pend.delete();
        ready.delete();
        rst_n = 1'b0;
        #1;
        chk("reset_rd_zero", {24'h0, rd_q}, 32'h0);
        @(posedge clk); #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_value", {24'h0, rd_q}, 32'h0);
        #1 rst_n = 1'b1;

        // Loader builds an instruction byte by byte
        step(1'b1, 32'h0, 8'h17, 4'b0001, 32'h0, 32'h1000_0000, 32'h0, 32'h0, 4'b0000);
        step(1'b1, 32'h1, 8'h07, 4'b0010, 32'h0, 32'h1000_0000, 32'h0, 32'h0, 4'b0000);
        step(1'b1, 32'h2, 8'h00, 4'b0100, 32'h0, 32'h1000_0000, 32'h0, 32'h0, 4'b0000);
        step(1'b1, 32'h3, 8'h10, 4'b1000, 32'h0, 32'h1000_0000, 32'h0, 32'h0, 4'b0000);
        idle(32'h2, 32'h0, 32'h1000_0000);
        sample();
        chk("t1_fetch", iram_q, 32'h1000_0717);
        idle(32'h3, 32'h0, 32'h1000_0000);
        sample();
        chk("t1_loader_rd", {24'h0, rd_q}, 32'h0000_0000);

        // Loader into DRAM
        step(1'b1, 32'h1000_0005, 8'hAA, 4'b0010, 32'h0, 32'h1000_0004, 32'h0, 32'h0, 4'b0000);
        idle(32'h1000_0005, 32'h0, 32'h1000_0004);
        sample();
        chk("t2_dram_lane1", {24'h0, dram_q[15:8]}, 32'h0000_00AA);
        idle(32'h0, 32'h0, 32'h1000_0004);
        sample();
        chk("t2_loader_rd", {24'h0, rd_q}, 32'h0000_00AA);

        // Core stores with partial byte enable
        step(1'b0, 32'h0, 8'h00, 4'b0000, 32'h0, 32'h1000_0010, 32'h1000_0010, 32'hDEAD_BEEF, 4'b1111);
        step(1'b0, 32'h0, 8'h00, 4'b0000, 32'h0, 32'h1000_0010, 32'h1000_0010, 32'h1122_3344, 4'b0100);
        idle(32'h0, 32'h0, 32'h1000_0010);
        sample();
        chk("t3_store_merge", dram_q, 32'hDE22_BEEF);

        // Ownership gating
        step(1'b1, 32'h0000_0100, 8'h00, 4'b0000, 32'h0, 32'h1000_0010, 32'h1000_0010, 32'h0, 4'b1111);
        step(1'b0, 32'h0, 8'hFF, 4'b0001, 32'h0, 32'h1000_0010, 32'h1000_0100, 32'h0, 4'b0000);
        idle(32'h0, 32'h0, 32'h1000_0010);
        sample();
        chk("t4_cpu_blocked", dram_q, 32'hDE22_BEEF);
        chk("t4_loader_blocked", iram_q, 32'h1000_0717);

        // Multi-lane loader enable replicates the byte
        step(1'b1, 32'h0000_0040, 8'h3C, 4'b1011, 32'h0, 32'h1000_0000, 32'h0, 32'h0, 4'b0000);
        idle(32'h0, 32'h0000_0040, 32'h1000_0000);
        sample();
        chk("multi_lane", {8'h00, iram_q[23:16] & 8'h00, iram_q[15:0]}, 32'h0000_3C3C);
        chk("multi_lane_hi", {24'h0, iram_q[31:24]}, 32'h0000_003C);

        // Wrap and reset
        step(1'b1, IB + 1, 8'h5A, 4'b0010, 32'h0, 32'h1000_0010, 32'h0, 32'h0, 4'b0000);
        idle(32'h0, 32'h0, 32'h1000_0010);
        sample();
        chk("t5_wrap", iram_q, 32'h1000_5A17);
        do_reset();
        idle(32'h1, 32'h0, 32'h1000_0010);
        sample();
        chk("t5_keep_iram", iram_q, 32'h1000_5A17);
        chk("t5_keep_dram", dram_q, 32'hDE22_BEEF);

        // Fill a small window of both regions, then random traffic over aliased addresses
        for (int w = 0; w < 16; w++) begin
            for (int l = 0; l < 4; l++) begin
                step(1'b1, mk_addr(w, l, 1'b0), 8'($urandom), 4'(1 << l), 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000);
                step(1'b1, mk_addr(w, l, 1'b1), 8'($urandom), 4'(1 << l), 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000);
            end
        end
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            step(1'($urandom_range(0, 1)),
                 mk_addr($urandom_range(0, 15), $urandom_range(0, 3), 1'($urandom_range(0, 1))),
                 8'($urandom), 4'($urandom),
                 mk_addr($urandom_range(0, 15), 0, 1'b0),
                 mk_addr($urandom_range(0, 15), $urandom_range(0, 3), 1'b1),
                 mk_addr($urandom_range(0, 15), 0, 1'b1),
                 $urandom, 4'($urandom));
        end
        idle(32'h0, 32'h0, 32'h1000_0000);
        repeat (3) @(posedge clk);
        sample();
        chk("queues_drained", 32'(pend.size() + ready.size() + cq.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hxd_ram.md
Name: hxd_ram

Overview:
- Unified instruction/data memory for the hxd32 SoC.
- Holds a word-organised IRAM (base 0x0000_0000) and a DRAM (base 0x1000_0000).
- Port A is the UART loader port (ram_rw): byte-wide reads and writes, owns the memory while the CPU is held in reset.
- Port B is the hxd32 core: instruction fetch from IRAM plus 32-bit data read/write with byte enables to DRAM.

Parameters:
XLEN, 32, data/address width of CPU ports (only 32 supported)
IRAM_DEPTH, 2048, IRAM size in 32-bit words (power of two)
DRAM_DEPTH, 2048, DRAM size in 32-bit words (power of two)

Ports:
clk_i  in  1  clock, all writes on rising edge
rst_n_i  in  1  asynchronous active-low reset
ram_rw_sel_i  in  1  1 = loader owns memory, 0 = CPU owns memory
ram_rw_addr_i  in  XLEN  loader byte address
ram_wr_data_i  in  8  loader write byte
ram_wr_byte_en_i  in  4  loader write lane enables (one-hot in normal use)
iram_rd_addr_i  in  XLEN  CPU fetch byte address
dram_rd_addr_i  in  XLEN  CPU load byte address
dram_wr_addr_i  in  XLEN  CPU store byte address
dram_wr_data_i  in  XLEN  CPU store data, lane-aligned
dram_wr_byte_en_i  in  4  CPU store lane enables
iram_rd_data_o  out  XLEN  fetched instruction word
dram_rd_data_o  out  XLEN  loaded data word
ram_rd_data_o  out  8  loader read byte

Behaviour:
- Region decode, loader port: address bit 28 = 0 selects IRAM, bit 28 = 1 selects DRAM.
- Word index = addr[log2(DEPTH)+1:2]. Upper bits are ignored, so addresses wrap modulo region size. Lane = addr[1:0].
- Byte lanes are little-endian: lane n = bits [8n+7:8n].
- Loader write: on rising clk when ram_rw_sel_i=1, each set bit n of ram_wr_byte_en_i writes ram_wr_data_i into lane n of the selected word.
- Loader read: ram_rd_data_o is registered. On every rising edge it loads the byte at lane ram_rw_addr_i[1:0] of the decoded word, so there is one-cycle latency. Read-during-write returns the old byte.
- CPU fetch: iram_rd_data_o = IRAM[iram_rd_addr_i index]. Combinational, zero latency, no bit-28 decode.
- CPU load: dram_rd_data_o = DRAM[dram_rd_addr_i index]. Combinational, zero latency, full word; the core extracts bytes and halfwords.
- CPU store: on rising clk when ram_rw_sel_i=0, each set bit n of dram_wr_byte_en_i writes lane n of dram_wr_data_i into DRAM[dram_wr_addr_i index]. Unenabled lanes keep their value. The core cannot write IRAM.
- Ownership:
  - ram_rw_sel_i=1: CPU stores are ignored.
  - ram_rw_sel_i=0: loader writes are ignored.
  - CPU reads are always live regardless of ram_rw_sel_i.
  - ram_rd_data_o keeps updating in both modes.
- Combinational read ports show pre-edge contents in the write cycle and new contents after the edge.
- Reset: ram_rd_data_o <= 8'h00. Memory arrays are not cleared (contents undefined at power-up, retained across rst_n_i).
- Byte enable 4'b0000 on either port: no write.
- Multiple loader enable bits set: the same byte is written to every enabled lane.

Test Plan:
1. Loader write, sel=1: bytes 0x17, 0x07, 0x00, 0x10 to addresses 0x0–0x3 with en 0001/0010/0100/1000 -> iram_rd_data_o at addr 0 = 0x10000717. Loader reads of addr 0x2 return 0x00 one cycle after the address is applied.
2. Loader DRAM path: write 0xAA to addr 0x1000_0005 with en=0010 -> dram_rd_data_o at addr 0x1000_0004 has [15:8]=0xAA. Loader read of 0x1000_0005 returns 0xAA.
3. CPU store, sel=0: dram_wr_addr=0x1000_0010, data=0xDEADBEEF, en=1111, then a second store with data 0x11223344, en=0100 -> dram_rd_data_o=0xDE22BEEF.
4. Ownership: sel=1 with CPU store en=1111 -> DRAM unchanged. sel=0 with loader en=0001 -> IRAM unchanged.
5. Wrap and reset:
   - Loader write to addr IRAM_DEPTH*4 lands at word 0.
   - Assert rst_n_i mid-run -> ram_rd_data_o=0x00 immediately; memory contents are preserved.
